// File: rtl/ieee754_fpu_arbiter.sv
// ieee754_fpu_arbiter: round-robin arbiter/sequencer sharing one multi-cycle FP core among N_REQ requesters
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o  per-requester operation handshake (ready is one-hot or zero, IDLE only)
//   req_op_i/req_a_i/req_b_i packed per-requester opcode and operands
//   fpu_start_o              one-cycle issue pulse to the core
//   fpu_op_o/fpu_a_o/fpu_b_o registered operation, stable until done/timeout
//   fpu_done_i/fpu_result_i/fpu_flags_i  core completion, result and flags
//   rsp_valid_o/rsp_ready_i  one-hot response handshake to the granted requester
//   rsp_result_o/rsp_flags_o/rsp_timeout_o  held response payload
module ieee754_fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int OP_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*OP_W-1:0] req_op_i,
    input  logic [N_REQ*32-1:0]   req_a_i,
    input  logic [N_REQ*32-1:0]   req_b_i,
    output logic                  fpu_start_o,
    output logic [OP_W-1:0]       fpu_op_o,
    output logic [31:0]           fpu_a_o,
    output logic [31:0]           fpu_b_o,
    input  logic                  fpu_done_i,
    input  logic [31:0]           fpu_result_i,
    input  logic [4:0]            fpu_flags_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic [31:0]           rsp_result_o,
    output logic [4:0]            rsp_flags_o,
    output logic                  rsp_timeout_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state_q;
    logic [PW-1:0]   ptr_q, grant_q, win, cand;
    logic [CW-1:0]   cnt_q;
    logic            found;
    logic [OP_W-1:0] sel_op;
    logic [31:0]     sel_a, sel_b;

    // First valid requester scanning ptr, ptr+1, ... modulo N_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_op = req_op_i[i*OP_W +: OP_W];
                sel_a  = req_a_i[i*32 +: 32];
                sel_b  = req_b_i[i*32 +: 32];
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && found) ? (N_REQ'(1) << win) : '0;
    assign rsp_valid_o = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
    assign fpu_start_o = state_q == ISSUE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            fpu_op_o      <= '0;
            fpu_a_o       <= '0;
            fpu_b_o       <= '0;
            rsp_result_o  <= '0;
            rsp_flags_o   <= '0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    grant_q  <= win;
                    fpu_op_o <= sel_op;
                    fpu_a_o  <= sel_a;
                    fpu_b_o  <= sel_b;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                // A done landing on the terminal count still returns the core result
                WAIT: if (fpu_done_i) begin
                    rsp_result_o  <= fpu_result_i;
                    rsp_flags_o   <= fpu_flags_i;
                    rsp_timeout_o <= 1'b0;
                    state_q       <= RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_result_o  <= 32'h7FC0_0000;
                    rsp_flags_o   <= 5'b10000;
                    rsp_timeout_o <= 1'b1;
                    state_q       <= RESP;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: if (rsp_ready_i[grant_q]) begin
                    ptr_q   <= (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ieee754_fpu_arbiter.sv
// tb_ieee754_fpu_arbiter: table-driven, directed and randomized checks of the FP core arbiter
module tb_ieee754_fpu_arbiter;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0, req_ready;
    logic [7:0]   req_op = '0;
    logic [127:0] req_a = '0, req_b = '0;
    logic         fpu_start, fpu_done = 1'b0;
    logic [1:0]   fpu_op;
    logic [31:0]  fpu_a, fpu_b, fpu_result = '0;
    logic [4:0]   fpu_flags = '0;
    logic [3:0]   rsp_valid, rsp_ready = '0;
    logic [31:0]  rsp_result;
    logic [4:0]   rsp_flags;
    logic         rsp_timeout;

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    int grants[$];

    typedef struct {
        logic [3:0]  v;
        int          lat;
        int          bp;
        int          w;
        logic [31:0] a, b, res;
        logic [4:0]  fl;
    } vec_t;
    vec_t tbl[9];

    ieee754_fpu_arbiter #(.N_REQ(4), .OP_W(2), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .fpu_start_o(fpu_start), .fpu_op_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
        .fpu_done_i(fpu_done), .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_timeout_o(rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid requester at or after the model pointer
    function automatic int model_win(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[(mptr + k) % 4]) return (mptr + k) % 4;
        return -1;
    endfunction

    // One full transaction. lat = cycles from start to done (0 = never);
    // done is expected to win up to lat == TO, anything later is a timeout.
    task automatic run_op(input logic [3:0] v, input int lat, input int bp, input logic [3:0] hold,
                          input int ew, input logic [31:0] fa, input logic [31:0] fb,
                          input logic [31:0] fres, input logic [4:0] ffl);
        int eff, c;
        bit to_exp, seen;
        logic [3:0] oh;
        logic [1:0] eop;
        logic [31:0] er;
        logic [4:0] ef;
        to_exp = (lat == 0 || lat > TO);
        eff = to_exp ? TO : lat;
        er = to_exp ? 32'h7FC0_0000 : fres;
        ef = to_exp ? 5'b10000 : ffl;
        oh = 4'b0001 << ew;
        @(negedge clk);
        fpu_done = 1'b0;
        rsp_ready = '0;
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
            req_op[i*2 +: 2] = 2'($urandom);
        end
        req_a[ew*32 +: 32] = fa;
        req_b[ew*32 +: 32] = fb;
        eop = req_op[ew*2 +: 2];
        #1 chk("req_ready_grant", req_ready, oh);
        @(negedge clk);
        req_valid = hold;
        #1;
        chk("fpu_start_pulse", fpu_start, 1);
        chk("fpu_a", fpu_a, fa);
        chk("fpu_b", fpu_b, fb);
        chk("fpu_op", fpu_op, eop);
        chk("req_ready_issue", req_ready, 0);
        seen = 0;
        c = 2;
        while (!seen && c <= TO + 4) begin
            @(negedge clk);
            fpu_done = (c == lat + 1);
            fpu_result = fpu_done ? fres : $urandom;
            fpu_flags = fpu_done ? ffl : 5'($urandom);
            req_valid = hold;
            #1;
            if (rsp_valid != 0) seen = 1;
            else begin
                chk("fpu_start_wait", fpu_start, 0);
                chk("fpu_a_stable", fpu_a, fa);
                chk("req_ready_wait", req_ready, 0);
                c++;
            end
        end
        chk("rsp_latency", c, 2 + eff);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_result", rsp_result, er);
        chk("rsp_flags", rsp_flags, ef);
        chk("rsp_timeout", rsp_timeout, to_exp);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            fpu_done = 1'b0;
            rsp_ready = 4'($urandom) & ~oh;
            req_valid = hold;
            #1;
            chk("bp_rsp_valid", rsp_valid, oh);
            chk("bp_rsp_result", rsp_result, er);
            chk("bp_rsp_flags", rsp_flags, ef);
            chk("bp_req_ready", req_ready, 0);
        end
        @(negedge clk);
        fpu_done = 1'b0;
        rsp_ready = 4'($urandom) | oh;
        req_valid = hold;
        #1 chk("rsp_take_valid", rsp_valid, oh);
        chk("rsp_take_ready", req_ready, 0);
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
        fpu_done = (lat == 0);
        #1 chk("rsp_dropped", rsp_valid, 0);
        mptr = (ew + 1) % 4;
        grants.push_back(ew);
    endtask

    initial begin
        tbl[0] = '{4'b0001, 3, 0, 0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000};
        tbl[1] = '{4'b0001, 1, 2, 0, 32'hC120_0000, 32'h3F00_0000, 32'hC0A0_0000, 5'b00001};
        tbl[2] = '{4'b1010, 5, 0, 1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 5'b00101};
        tbl[3] = '{4'b1010, 2, 0, 3, 32'h0000_0001, 32'h3E80_0000, 32'h0000_0000, 5'b00011};
        tbl[4] = '{4'b0100, TO, 1, 2, 32'h4120_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000};
        tbl[5] = '{4'b0110, 0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hAAAA_5555, 5'b11111};
        tbl[6] = '{4'b0001, TO + 1, 3, 0, 32'hFF80_0000, 32'h7F80_0000, 32'h5555_AAAA, 5'b00000};
        tbl[7] = '{4'b0100, 2, 10, 2, 32'h4049_0FDB, 32'h402D_F854, 32'h40C5_04C9, 5'b00001};
        tbl[8] = '{4'b1111, 1, 0, 3, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00000};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].v, tbl[i].lat, tbl[i].bp, 4'hF, tbl[i].w,
                   tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].fl);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] v;
            v = 4'($urandom_range(1, 15));
            run_op(v, $urandom_range(0, TO + 1), $urandom_range(0, 3), 4'($urandom),
                   model_win(v), $urandom, $urandom, $urandom, 5'($urandom));
        end

        // Reset during WAIT aborts the operation silently
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'hDEAD_BEEF;
        req_b[64 +: 32] = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fpu_start", fpu_start, 0);
        chk("arst_fpu_a", fpu_a, 0);
        chk("arst_fpu_b", fpu_b, 0);
        chk("arst_fpu_op", fpu_op, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_result", rsp_result, 0);
        chk("arst_rsp_flags", rsp_flags, 0);
        chk("arst_rsp_timeout", rsp_timeout, 0);
        chk("arst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fpu_done = 1'b1;
        fpu_result = 32'h4040_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fpu_done = 1'b0;
            #1 chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_start", fpu_start, 0);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1 chk("post_rst_grant0", req_ready, 4'b0001);
        req_valid = '0;
        mptr = 0;

        // Fairness with every requester continuously valid
        grants.delete();
        for (int n = 0; n < 6; n++)
            run_op(4'hF, $urandom_range(1, 4), 0, 4'hF, model_win(4'hF),
                   $urandom, $urandom, $urandom, 5'($urandom));
        for (int n = 0; n < 6; n++)
            chk("fair_order", grants[n], n % 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
